// File: rtl/perf_pkg.sv
// Shared types and helpers for the perf_counter_bank profiling block.
// Counter widths up to 64 bits are supported by sat_inc.
package perf_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } ch_state_e;

    localparam logic [1:0] FLD_BUSY   = 2'd0;
    localparam logic [1:0] FLD_OPS    = 2'd1;
    localparam logic [1:0] FLD_MAXLAT = 2'd2;
    localparam logic [1:0] FLD_STATUS = 2'd3;

    localparam int unsigned STAT_OVL  = 0;
    localparam int unsigned STAT_SAT  = 1;
    localparam int unsigned STAT_BUSY = 2;
    localparam int unsigned STAT_W    = 3;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (val >= max_val) ? max_val : val + 64'd1;
    endfunction

endpackage

// File: rtl/perf_ch_tracker.sv
// One start/done channel: IDLE/BUSY FSM, busy and op counters, sticky flags.
// Latency tracking (cur_lat/max_lat) exists only when PERF_MAX_LAT_EN is defined.
module perf_ch_tracker
    import perf_pkg::*;
#(
    parameter int unsigned CNT_W = 48,
    parameter int unsigned LAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              cnt_en,
    input  logic              flg_en,
    input  logic              start,
    input  logic              done,
    output logic              busy,
    output logic [CNT_W-1:0]  busy_cnt,
    output logic [CNT_W-1:0]  op_cnt,
    output logic [LAT_W-1:0]  max_lat,
    output logic [STAT_W-1:0] status
);

    ch_state_e         state_q, state_d;
    logic [CNT_W-1:0]  busy_cnt_q, busy_cnt_d;
    logic [CNT_W-1:0]  op_cnt_q, op_cnt_d;
    logic              ovl_q, ovl_d;
    logic              sat_q, sat_d;
    logic              op_done, busy_tick, ovl_hit;

    always_comb begin
        state_d   = state_q;
        op_done   = 1'b0;
        busy_tick = 1'b0;
        ovl_hit   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (done) op_done = 1'b1;
                    else      state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                busy_tick = 1'b1;
                if (done) begin
                    op_done = 1'b1;
                    if (!start) state_d = ST_IDLE;
                end else if (start) begin
                    ovl_hit = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear) state_d = ST_IDLE;
    end

    always_comb begin
        busy_cnt_d = busy_cnt_q;
        op_cnt_d   = op_cnt_q;
        ovl_d      = ovl_q;
        sat_d      = sat_q;
        if (clear) begin
            busy_cnt_d = '0;
            op_cnt_d   = '0;
            ovl_d      = 1'b0;
            sat_d      = 1'b0;
        end else begin
            if (cnt_en && busy_tick) begin
                busy_cnt_d = CNT_W'(sat_inc(64'(busy_cnt_q), CNT_W));
                if (busy_cnt_q == '1) sat_d = 1'b1;
            end
            if (cnt_en && op_done) begin
                op_cnt_d = CNT_W'(sat_inc(64'(op_cnt_q), CNT_W));
                if (op_cnt_q == '1) sat_d = 1'b1;
            end
            if (flg_en && ovl_hit) ovl_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            busy_cnt_q <= '0;
            op_cnt_q   <= '0;
            ovl_q      <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_cnt_q <= busy_cnt_d;
            op_cnt_q   <= op_cnt_d;
            ovl_q      <= ovl_d;
            sat_q      <= sat_d;
        end
    end

`ifdef PERF_MAX_LAT_EN
    logic [LAT_W-1:0] cur_lat_q, cur_lat_d;
    logic [LAT_W-1:0] max_lat_q, max_lat_d;
    logic [LAT_W-1:0] op_lat;
    logic             lat_restart;

    // A fresh op begins on IDLE start-without-done or on a back-to-back done+start.
    assign lat_restart = start && ((state_q == ST_IDLE) ? !done : done);

    always_comb begin
        cur_lat_d = cur_lat_q;
        max_lat_d = max_lat_q;
        op_lat    = '0;
        if (state_q == ST_BUSY) begin
            op_lat = LAT_W'(sat_inc(64'(cur_lat_q), LAT_W));
            if (!done) cur_lat_d = op_lat;
        end
        if (lat_restart) cur_lat_d = '0;
        if (clear) begin
            cur_lat_d = '0;
            max_lat_d = '0;
        end else if (cnt_en && op_done && (op_lat > max_lat_q)) begin
            max_lat_d = op_lat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_lat_q <= '0;
            max_lat_q <= '0;
        end else begin
            cur_lat_q <= cur_lat_d;
            max_lat_q <= max_lat_d;
        end
    end

    assign max_lat = max_lat_q;
`else
    assign max_lat = '0;
`endif

    assign busy               = (state_q == ST_BUSY);
    assign busy_cnt           = busy_cnt_q;
    assign op_cnt             = op_cnt_q;
    assign status[STAT_OVL]   = ovl_q;
    assign status[STAT_SAT]   = sat_q;
    assign status[STAT_BUSY]  = busy;

endmodule

// File: rtl/perf_counter_bank.sv
// Multi-channel cycle-accounting bank: global run/starve counters plus per-channel
// trackers behind a registered read port. Optional max latency via PERF_MAX_LAT_EN.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 48,
    parameter int unsigned LAT_W  = 16,
    parameter int unsigned SEL_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              src_valid,
    input  logic [NUM_CH-1:0] ch_start,
    input  logic [NUM_CH-1:0] ch_done,
    input  logic              clear,
    input  logic              freeze,
    input  logic              rd_en,
    input  logic [SEL_W-1:0]  rd_ch,
    input  logic [1:0]        rd_field,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_data,
    output logic [CNT_W-1:0]  total_cnt,
    output logic [CNT_W-1:0]  starve_cnt,
    output logic              busy_any
);

    logic             armed_q;
    logic [CNT_W-1:0] total_q, starve_q;
    logic             rd_valid_q;
    logic [CNT_W-1:0] rd_data_q, rd_mux;
    logic             cnt_en;

    logic [NUM_CH-1:0] ch_busy;
    logic [CNT_W-1:0]  ch_busy_cnt [NUM_CH];
    logic [CNT_W-1:0]  ch_op_cnt   [NUM_CH];
    logic [LAT_W-1:0]  ch_max_lat  [NUM_CH];
    logic [STAT_W-1:0] ch_status   [NUM_CH];

    // armed is registered, so the cycle that raises arm is never counted.
    assign cnt_en = armed_q && !freeze;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        perf_ch_tracker #(
            .CNT_W (CNT_W),
            .LAT_W (LAT_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .clear    (clear),
            .cnt_en   (cnt_en),
            .flg_en   (!freeze),
            .start    (ch_start[g]),
            .done     (ch_done[g]),
            .busy     (ch_busy[g]),
            .busy_cnt (ch_busy_cnt[g]),
            .op_cnt   (ch_op_cnt[g]),
            .max_lat  (ch_max_lat[g]),
            .status   (ch_status[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_q  <= 1'b0;
            total_q  <= '0;
            starve_q <= '0;
        end else if (clear) begin
            armed_q  <= 1'b0;
            total_q  <= '0;
            starve_q <= '0;
        end else begin
            if (arm) armed_q <= 1'b1;
            if (cnt_en) begin
                total_q <= CNT_W'(sat_inc(64'(total_q), CNT_W));
                if (!src_valid) starve_q <= CNT_W'(sat_inc(64'(starve_q), CNT_W));
            end
        end
    end

    // Unmatched selects (rd_ch >= NUM_CH) fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == SEL_W'(i)) begin
                case (rd_field)
                    FLD_BUSY:   rd_mux = ch_busy_cnt[i];
                    FLD_OPS:    rd_mux = ch_op_cnt[i];
                    FLD_MAXLAT: rd_mux = CNT_W'(ch_max_lat[i]);
                    default:    rd_mux = CNT_W'(ch_status[i]);
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) rd_data_q <= rd_mux;
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign total_cnt  = total_q;
    assign starve_cnt = starve_q;
    assign busy_any   = |ch_busy;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: a default-width instance and a narrow
// (CNT_W=4, NUM_CH=3) instance share the same stimulus.
module tb_perf_counter_bank;

`ifdef PERF_MAX_LAT_EN
    localparam bit LAT_ON = 1'b1;
`else
    localparam bit LAT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, arm, src_valid, clear, freeze, rd_en;
    logic [3:0]  ch_start, ch_done;
    logic [1:0]  rd_ch, rd_field;

    logic        rd_valid, busy_any;
    logic [47:0] rd_data, total_cnt, starve_cnt;
    logic        s_rd_valid, s_busy_any;
    logic [3:0]  s_rd_data, s_total, s_starve;

    int n_checks = 0;
    int n_fail   = 0;

    bit          exp_armed = 1'b0;
    logic [63:0] exp_total = '0;
    logic [63:0] exp_starve = '0;
    logic [63:0] t_snap;

    always #5 clk = ~clk;

    perf_counter_bank u_dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .src_valid  (src_valid),
        .ch_start   (ch_start),
        .ch_done    (ch_done),
        .clear      (clear),
        .freeze     (freeze),
        .rd_en      (rd_en),
        .rd_ch      (rd_ch),
        .rd_field   (rd_field),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .total_cnt  (total_cnt),
        .starve_cnt (starve_cnt),
        .busy_any   (busy_any)
    );

    perf_counter_bank #(
        .NUM_CH (3),
        .CNT_W  (4),
        .LAT_W  (4),
        .SEL_W  (2)
    ) u_small (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .src_valid  (src_valid),
        .ch_start   (ch_start[2:0]),
        .ch_done    (ch_done[2:0]),
        .clear      (clear),
        .freeze     (freeze),
        .rd_en      (rd_en),
        .rd_ch      (rd_ch),
        .rd_field   (rd_field),
        .rd_valid   (s_rd_valid),
        .rd_data    (s_rd_data),
        .total_cnt  (s_total),
        .starve_cnt (s_starve),
        .busy_any   (s_busy_any)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sat4(input logic [63:0] v);
        return (v > 64'd15) ? 64'd15 : v;
    endfunction

    // One clock; global counter model advances with the inputs seen at the edge.
    task automatic tick();
        @(posedge clk);
        if (clear) begin
            exp_armed  = 1'b0;
            exp_total  = '0;
            exp_starve = '0;
        end else begin
            if (exp_armed && !freeze) begin
                exp_total++;
                if (!src_valid) exp_starve++;
            end
            if (arm) exp_armed = 1'b1;
        end
        #1;
    endtask

    task automatic do_read(input string tag, input logic [1:0] ch, input logic [1:0] fld,
                           input logic [63:0] exp_b, input logic [63:0] exp_s);
        rd_en = 1'b1; rd_ch = ch; rd_field = fld;
        tick();
        rd_en = 1'b0;
        check_eq({tag, "_valid"}, 64'(rd_valid), 64'd1);
        check_eq({tag, "_data"}, 64'(rd_data), exp_b);
        check_eq({tag, "_s_valid"}, 64'(s_rd_valid), 64'd1);
        check_eq({tag, "_s_data"}, 64'(s_rd_data), exp_s);
        tick();
        check_eq({tag, "_valid_drop"}, 64'(rd_valid), 64'd0);
        check_eq({tag, "_hold"}, 64'(rd_data), exp_b);
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; src_valid = 1'b1; clear = 1'b0; freeze = 1'b0;
        rd_en = 1'b0; ch_start = '0; ch_done = '0; rd_ch = '0; rd_field = '0;
        repeat (3) tick();
        check_eq("rst_total", 64'(total_cnt), 64'd0);
        check_eq("rst_starve", 64'(starve_cnt), 64'd0);
        check_eq("rst_busy_any", 64'(busy_any), 64'd0);
        check_eq("rst_rd_valid", 64'(rd_valid), 64'd0);
        check_eq("rst_rd_data", 64'(rd_data), 64'd0);
        rst = 1'b0;
        tick();

        // Arm (arm cycle itself not counted, even with src_valid low), then 100 cycles.
        arm = 1'b1; src_valid = 1'b0;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 100; i++) begin
            ch_start = {i == 60, 1'b0, (i == 30) || (i == 40) || (i == 43), i == 10};
            ch_done  = {i == 62, 1'b0, (i == 30) || (i == 43) || (i == 47), i == 15};
            src_valid = !(i >= 50 && i < 57);
            tick();
        end
        ch_start = '0; ch_done = '0; src_valid = 1'b1;
        check_eq("total_100", 64'(total_cnt), 64'd100);
        check_eq("starve_7", 64'(starve_cnt), 64'd7);
        check_eq("s_total_sat", 64'(s_total), 64'd15);
        check_eq("s_starve_7", 64'(s_starve), 64'd7);
        check_eq("idle_busy_any", 64'(busy_any), 64'd0);
        do_read("ch0_busy", 2'd0, 2'd0, 64'd5, 64'd5);
        do_read("ch0_ops", 2'd0, 2'd1, 64'd1, 64'd1);
        do_read("ch0_lat", 2'd0, 2'd2, LAT_ON ? 64'd5 : 64'd0, LAT_ON ? 64'd5 : 64'd0);
        do_read("ch1_busy", 2'd1, 2'd0, 64'd7, 64'd7);
        do_read("ch1_ops", 2'd1, 2'd1, 64'd3, 64'd3);
        do_read("ch1_lat", 2'd1, 2'd2, LAT_ON ? 64'd4 : 64'd0, LAT_ON ? 64'd4 : 64'd0);
        do_read("ch3_ops", 2'd3, 2'd1, 64'd1, 64'd0);
        do_read("ch3_busy", 2'd3, 2'd0, 64'd2, 64'd0);

        // Overlapping start on ch1 sets ovl_err while the op continues.
        ch_start = 4'b0010;
        tick();
        tick();
        ch_start = '0;
        do_read("ch1_ovl_status", 2'd1, 2'd3, 64'd5, 64'd5);
        ch_done = 4'b0010;
        tick();
        ch_done = '0;
        check_eq("ovl_done_idle", 64'(busy_any), 64'd0);

        // ch2 busy for 20 cycles: narrow instance saturates at 15.
        ch_start = 4'b0100;
        tick();
        ch_start = '0;
        repeat (19) tick();
        ch_done = 4'b0100;
        tick();
        ch_done = '0;
        do_read("ch2_busy", 2'd2, 2'd0, 64'd20, 64'd15);
        do_read("ch2_status", 2'd2, 2'd3, 64'd0, 64'd2);
        do_read("ch2_ops", 2'd2, 2'd1, 64'd1, 64'd1);
        do_read("ch2_lat", 2'd2, 2'd2, LAT_ON ? 64'd20 : 64'd0, LAT_ON ? 64'd15 : 64'd0);

        // Freeze mid-op on ch0 for 10 cycles.
        ch_start = 4'b0001;
        tick();
        ch_start = '0;
        tick();
        tick();
        check_eq("pre_freeze_total", 64'(total_cnt), exp_total);
        t_snap = exp_total;
        freeze = 1'b1; src_valid = 1'b0;
        repeat (8) tick();
        check_eq("frozen_busy_any", 64'(busy_any), 64'd1);
        do_read("frozen_ch0_busy", 2'd0, 2'd0, 64'd7, 64'd7);
        check_eq("frozen_total", 64'(total_cnt), t_snap);
        check_eq("frozen_s_total", 64'(s_total), sat4(t_snap));

        // clear wins over freeze, arm and start in the same cycle.
        clear = 1'b1; arm = 1'b1; ch_start = 4'hF;
        tick();
        clear = 1'b0; arm = 1'b0; ch_start = '0; freeze = 1'b0;
        check_eq("clr_total", 64'(total_cnt), 64'd0);
        check_eq("clr_starve", 64'(starve_cnt), 64'd0);
        check_eq("clr_busy_any", 64'(busy_any), 64'd0);
        check_eq("clr_s_total", 64'(s_total), 64'd0);
        repeat (3) tick();
        src_valid = 1'b1;
        check_eq("clr_disarmed_total", 64'(total_cnt), 64'd0);
        check_eq("clr_disarmed_starve", 64'(starve_cnt), 64'd0);
        do_read("clr_ch0_busy", 2'd0, 2'd0, 64'd0, 64'd0);
        do_read("clr_ch0_ops", 2'd0, 2'd1, 64'd0, 64'd0);
        do_read("clr_ch1_status", 2'd1, 2'd3, 64'd0, 64'd0);
        do_read("clr_ch2_status", 2'd2, 2'd3, 64'd0, 64'd0);

        // 5-cycle op, then asynchronous reset in the middle of a second op.
        arm = 1'b1;
        tick();
        arm = 1'b0;
        ch_start = 4'b0001;
        tick();
        ch_start = '0;
        repeat (4) tick();
        ch_done = 4'b0001;
        tick();
        ch_done = '0;
        do_read("op5_ops", 2'd0, 2'd1, 64'd1, 64'd1);
        do_read("op5_lat", 2'd0, 2'd2, LAT_ON ? 64'd5 : 64'd0, LAT_ON ? 64'd5 : 64'd0);
        ch_start = 4'b0001;
        tick();
        ch_start = '0;
        tick();
        check_eq("midop_busy_any", 64'(busy_any), 64'd1);
        check_eq("midop_total", 64'(total_cnt), exp_total);
        #2 rst = 1'b1;
        exp_armed = 1'b0; exp_total = '0; exp_starve = '0;
        #1;
        check_eq("arst_total", 64'(total_cnt), 64'd0);
        check_eq("arst_starve", 64'(starve_cnt), 64'd0);
        check_eq("arst_busy_any", 64'(busy_any), 64'd0);
        check_eq("arst_rd_valid", 64'(rd_valid), 64'd0);
        check_eq("arst_rd_data", 64'(rd_data), 64'd0);
        check_eq("arst_s_rd_data", 64'(s_rd_data), 64'd0);
        check_eq("arst_s_busy_any", 64'(s_busy_any), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        do_read("post_rst_busy", 2'd0, 2'd0, 64'd0, 64'd0);
        do_read("post_rst_ops", 2'd0, 2'd1, 64'd0, 64'd0);
        check_eq("post_rst_total", 64'(total_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
